mul_dot_accum: RTL

- Accumulator stage directly downstream of the 8x8 multiplier.
- Consumes one unsigned 16-bit product per handshake and sums LEN products, or fewer if the frame is terminated early, into an ACC_W-bit dot-product result.
- Presents the result on a valid/ready output port and flags overflow.
- Turns the combinational product stream into framed, back-pressured dot-product results for the downstream datapath.

---
 rtl/mul_dot_accum.sv | 89 ++++++++
 1 files changed

// File: rtl/mul_dot_accum.sv
// Frames an unsigned 16-bit product stream into ACC_W-bit dot-product results with overflow flag.
// Optional MUL_ACC_SATURATE_EN: clamp the frame sum at 2^ACC_W-1 instead of wrapping.
module mul_dot_accum #(
  parameter int LEN   = 8,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  typedef enum logic {ACC, DONE} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf_flag;

  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] res;
  logic             accept;
  logic             close;

  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, in_prod};
    carry   = sum_ext[ACC_W];
`ifdef MUL_ACC_SATURATE_EN
    // once clamped, the rest of the frame stays at full scale
    res     = (carry || ovf_flag) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    res     = sum_ext[ACC_W-1:0];
`endif
    accept  = in_valid && in_ready && (state == ACC);
    close   = in_last || (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      ovf_flag  <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (close) begin
              out_sum   <= res;
              out_ovf   <= ovf_flag | carry;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= DONE;
              acc       <= '0;
              cnt       <= '0;
              ovf_flag  <= 1'b0;
            end else begin
              acc      <= res;
              cnt      <= cnt + 1'b1;
              ovf_flag <= ovf_flag | carry;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end
endmodule
